// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C blocks: controller state encoding, R/W bit values
// and the board's default target address.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WDATA,
    WACK,
    RDATA,
    MNACK,
    STOP,
    DONE
  } i2c_state_e;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h2A;

endpackage

// File: rtl/i2c_if.sv
// Command/response interface between the bus register block (master side) and
// the I2C controller (slave side, i.e. the block that serves the request).
interface i2c_if;
  logic       start;
  logic [6:0] addr;
  logic       rw;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       ack_err;

  modport master (
    output start, addr, rw, wdata,
    input  rdata, busy, done, ack_err
  );

  modport slave (
    input  start, addr, rw, wdata,
    output rdata, busy, done, ack_err
  );
endinterface

// File: rtl/i2c_tick_gen.sv
// Quarter-period divider: counts 0..CLK_DIV-1 while enabled and flags the wrap cycle.
// Disabling it parks the count at zero so every transfer starts on a fresh quarter.
module i2c_tick_gen #(
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             tick,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C controller: START, address+R/W, ACK, one data byte, ACK/NACK, STOP.
// Every bit slot is four quarter ticks; SCL is low for Q0/Q1 and released for Q2/Q3.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = 16
) (
  input  logic  clk,
  input  logic  rst_n,
  i2c_if.slave  cmd,
  inout  wire   sda,
  inout  wire   scl
);

  i2c_state_e       state, state_nxt;
  logic [1:0]       q;
  logic [2:0]       bit_cnt;
  logic [7:0]       tx_sh, rx_sh, wdata_q, rdata_r;
  logic             rw_q, sda_smp, ack_err_r;
  logic             en, tick, sample_pt, slot_end, accept;
  logic             sda_low, scl_low;
  logic [CNT_W-1:0] div_cnt;

  assign en       = (state != IDLE) && (state != DONE);
  assign slot_end = tick && (q == 2'd3);
  assign accept   = (state == IDLE) && cmd.start;
  // Sample half a quarter into the SCL-high phase so SDA has settled.
  assign sample_pt = en && (q == 2'd2) && (div_cnt == CNT_W'(CLK_DIV / 2));

  i2c_tick_gen #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .tick  (tick),
    .cnt   (div_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q         <= '0;
      bit_cnt   <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      wdata_q   <= '0;
      rdata_r   <= '0;
      rw_q      <= 1'b0;
      sda_smp   <= 1'b0;
      ack_err_r <= 1'b0;
    end else begin
      if (accept) begin
        tx_sh     <= {cmd.addr, cmd.rw};
        rw_q      <= cmd.rw;
        wdata_q   <= cmd.wdata;
        ack_err_r <= 1'b0;
      end
      if (tick) begin
        q <= q + 2'd1;
      end
      if (sample_pt) begin
        sda_smp <= sda;
      end
      if (slot_end) begin
        case (state)
          ADDR, WDATA: begin
            tx_sh   <= {tx_sh[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
          end
          RDATA: begin
            rx_sh   <= {rx_sh[6:0], sda_smp};
            bit_cnt <= bit_cnt + 3'd1;
          end
          ADDR_ACK: begin
            if (sda_smp) ack_err_r <= 1'b1;
            tx_sh <= wdata_q;
          end
          WACK: begin
            if (sda_smp) ack_err_r <= 1'b1;
          end
          MNACK: begin
            rdata_r <= rx_sh;
          end
          default: ;
        endcase
      end
    end
  end

  // Bit counter wraps 7->0 on the last slot of a byte, so 7 marks the final slot.
  always_comb begin
    state_nxt = state;
    sda_low   = 1'b0;
    scl_low   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd.start) state_nxt = START;
      end
      START: begin
        sda_low = (q != 2'd0);
        scl_low = (q == 2'd3);
        if (slot_end) state_nxt = ADDR;
      end
      ADDR: begin
        sda_low = !tx_sh[7];
        scl_low = (q < 2'd2);
        if (slot_end && (bit_cnt == 3'd7)) state_nxt = ADDR_ACK;
      end
      ADDR_ACK: begin
        scl_low = (q < 2'd2);
        if (slot_end) begin
          if (sda_smp)                   state_nxt = STOP;
          else if (rw_q == I2C_RW_READ)  state_nxt = RDATA;
          else                           state_nxt = WDATA;
        end
      end
      WDATA: begin
        sda_low = !tx_sh[7];
        scl_low = (q < 2'd2);
        if (slot_end && (bit_cnt == 3'd7)) state_nxt = WACK;
      end
      WACK: begin
        scl_low = (q < 2'd2);
        if (slot_end) state_nxt = STOP;
      end
      RDATA: begin
        scl_low = (q < 2'd2);
        if (slot_end && (bit_cnt == 3'd7)) state_nxt = MNACK;
      end
      MNACK: begin
        scl_low = (q < 2'd2);
        if (slot_end) state_nxt = STOP;
      end
      STOP: begin
        sda_low = (q != 2'd3);
        scl_low = (q == 2'd0);
        if (slot_end) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign sda = sda_low ? 1'b0 : 1'bz;
  assign scl = scl_low ? 1'b0 : 1'bz;

  assign cmd.busy    = en;
  assign cmd.done    = (state == DONE);
  assign cmd.rdata   = rdata_r;
  assign cmd.ack_err = ack_err_r;

endmodule
